// File: rtl/cim_psum_collector_pkg.sv
// Shared types and width helpers for the CIM partial-sum collector.
package cim_psum_pkg;

    typedef enum logic {
        PSUM_MODE_ALIGNED = 1'b0,
        PSUM_MODE_SERIAL  = 1'b1
    } psum_mode_e;

    // Bits needed to encode the values 0..n-1, never fewer than one bit.
    function automatic int psum_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/cim_psum_collector_if.sv
// Column-result input bus, control and psum output stream of the collector.
// The slave modport is the collector side; the master modport is the
// producer/consumer environment around it.
interface cim_psum_collector_if #(
    parameter int NUM_COLS    = 32,
    parameter int ODATA_WIDTH = 21,
    parameter int IDX_W       = 5
);
    logic                            mode;
    logic [NUM_COLS-1:0]             col_mask;
    logic [NUM_COLS-1:0]             acc_ready;
    logic [NUM_COLS*ODATA_WIDTH-1:0] mac_col_result;
    logic                            flush;
    logic                            out_valid;
    logic                            out_ready;
    logic [NUM_COLS*ODATA_WIDTH-1:0] out_data;
    logic [IDX_W-1:0]                out_col_idx;
    logic [NUM_COLS-1:0]             empty_vec;
    logic [NUM_COLS-1:0]             full_vec;
    logic [NUM_COLS-1:0]             overflow;

    modport slave (
        input  mode, col_mask, acc_ready, mac_col_result, flush, out_ready,
        output out_valid, out_data, out_col_idx, empty_vec, full_vec, overflow
    );

    modport master (
        output mode, col_mask, acc_ready, mac_col_result, flush, out_ready,
        input  out_valid, out_data, out_col_idx, empty_vec, full_vec, overflow
    );
endinterface

// File: rtl/cim_psum_collector_fifo.sv
// One column's partial-sum FIFO: arbitrary depth, exact occupancy count,
// sticky overflow flag on dropped pushes, synchronous flush.
module cim_psum_fifo
    import cim_psum_pkg::*;
#(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4,
    parameter int CNT_W = psum_width(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             overflow_o
);

    localparam int               PTR_W    = psum_width(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             overflow_q, overflow_d;
    logic             do_push_s, do_pop_s;

    // A pop needs data; a push needs room, which a same-cycle pop provides. Flush cancels both.
    always_comb begin
        do_pop_s  = pop_i & ~empty_q & ~flush_i;
        do_push_s = push_i & (~full_q | do_pop_s) & ~flush_i;
    end

    // Next pointers, count and sticky overflow; pointers wrap by explicit compare so any depth works.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (push_i & full_q & ~do_pop_s) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_FULL);
    end

    // Control state registers; empty/full are kept as flops so the flags leave the block registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array, zeroed on reset so the head reads a defined value when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_o     = mem_q[rd_ptr_q];
    assign empty_o    = empty_q;
    assign full_o     = full_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/cim_psum_collector.sv
// Per-column partial-sum collector: one FIFO per column, then either an
// ALIGNED wide beat (all enabled columns together) or a SERIAL round-robin
// stream of single columns tagged with their index.
module cim_psum_collector
    import cim_psum_pkg::*;
#(
    parameter int NUM_COLS    = 32,
    parameter int ODATA_WIDTH = 21,
    parameter int PSUM_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cim_psum_collector_if.slave    bus
);

    localparam int               CNT_W    = psum_width(PSUM_DEPTH + 1);
    localparam int               IDX_W    = psum_width(NUM_COLS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_COLS - 1);
    localparam logic [IDX_W:0]   IDX_WRAP = (IDX_W + 1)'(NUM_COLS);

    logic [NUM_COLS-1:0]             push_s, pop_s;
    logic [NUM_COLS-1:0]             empty_s, full_s, ovf_s;
    logic [ODATA_WIDTH-1:0]          head_s [NUM_COLS];
    logic [NUM_COLS-1:0]             cand_s;
    logic                            serial_s;
    logic                            valid_s;
    logic                            hs_s;
    logic [NUM_COLS*ODATA_WIDTH-1:0] data_s;
    logic [IDX_W-1:0]                idx_s;
    logic [IDX_W-1:0]                arb_grant_s;
    logic                            arb_found_s;
    logic [IDX_W-1:0]                sel_s;
    logic [IDX_W-1:0]                rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]                grant_q, grant_d;
    logic                            lock_q, lock_d;

    assign serial_s = (psum_mode_e'(bus.mode) == PSUM_MODE_SERIAL);
    assign cand_s   = bus.col_mask & ~empty_s;
    assign push_s   = bus.acc_ready & bus.col_mask;
    assign sel_s    = lock_q ? grant_q : arb_grant_s;
    assign hs_s     = valid_s & bus.out_ready & ~bus.flush;

    // Column FIFOs.
    for (genvar k = 0; k < NUM_COLS; k++) begin : g_col
        cim_psum_fifo #(
            .WIDTH (ODATA_WIDTH),
            .DEPTH (PSUM_DEPTH),
            .CNT_W (CNT_W)
        ) u_fifo (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush_i    (bus.flush),
            .push_i     (push_s[k]),
            .pop_i      (pop_s[k]),
            .data_i     (bus.mac_col_result[k*ODATA_WIDTH +: ODATA_WIDTH]),
            .head_o     (head_s[k]),
            .empty_o    (empty_s[k]),
            .full_o     (full_s[k]),
            .overflow_o (ovf_s[k])
        );
    end

    // Round-robin search: first candidate at or after rr_ptr, wrapping past the last column.
    always_comb begin
        arb_grant_s = '0;
        arb_found_s = 1'b0;
        for (int i = 0; i < NUM_COLS; i++) begin
            logic [IDX_W:0] pos_v;
            pos_v = {1'b0, rr_ptr_q} + (IDX_W + 1)'(i);
            if (pos_v >= IDX_WRAP) begin
                pos_v = pos_v - IDX_WRAP;
            end else begin
                pos_v = pos_v;
            end
            if (!arb_found_s && cand_s[pos_v[IDX_W-1:0]]) begin
                arb_found_s = 1'b1;
                arb_grant_s = pos_v[IDX_W-1:0];
            end else begin
                arb_found_s = arb_found_s;
            end
        end
    end

    // Output beat formation; data and index are forced to zero while no beat is offered.
    always_comb begin
        valid_s = 1'b0;
        data_s  = '0;
        idx_s   = '0;
        if (serial_s) begin
            valid_s = |cand_s;
            if (valid_s) begin
                data_s[ODATA_WIDTH-1:0] = head_s[sel_s];
                idx_s                   = sel_s;
            end else begin
                idx_s = '0;
            end
        end else begin
            valid_s = (bus.col_mask != '0) && ((bus.col_mask & empty_s) == '0);
            if (valid_s) begin
                for (int k = 0; k < NUM_COLS; k++) begin
                    if (bus.col_mask[k]) begin
                        data_s[k*ODATA_WIDTH +: ODATA_WIDTH] = head_s[k];
                    end else begin
                        data_s[k*ODATA_WIDTH +: ODATA_WIDTH] = '0;
                    end
                end
            end else begin
                data_s = '0;
            end
        end
    end

    // Pops on a handshake: every enabled column in ALIGNED mode, only the granted one in SERIAL.
    always_comb begin
        pop_s = '0;
        if (hs_s) begin
            if (serial_s) begin
                pop_s[sel_s] = 1'b1;
            end else begin
                pop_s = bus.col_mask;
            end
        end else begin
            pop_s = '0;
        end
    end

    // Arbiter next state: advance past the served column, or freeze the grant while stalled.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        lock_d   = lock_q;
        if (bus.flush) begin
            rr_ptr_d = '0;
            grant_d  = '0;
            lock_d   = 1'b0;
        end else if (hs_s && serial_s) begin
            rr_ptr_d = (sel_s == IDX_LAST) ? '0 : sel_s + 1'b1;
            lock_d   = 1'b0;
        end else if (serial_s && valid_s && !lock_q) begin
            lock_d  = 1'b1;
            grant_d = arb_grant_s;
        end else begin
            lock_d = lock_q;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            grant_q  <= '0;
            lock_q   <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            lock_q   <= lock_d;
        end
    end

    assign bus.out_valid   = valid_s;
    assign bus.out_data    = data_s;
    assign bus.out_col_idx = idx_s;
    assign bus.empty_vec   = empty_s;
    assign bus.full_vec    = full_s;
    assign bus.overflow    = ovf_s;

endmodule

// File: tb/tb_cim_psum_collector.sv
// Self-checking bench for cim_psum_collector (4 columns, depth 3): directed
// scenarios plus randomized traffic against a queue-based reference model.
module tb_cim_psum_collector;

    localparam int NC = 4;
    localparam int W  = 21;
    localparam int D  = 3;
    localparam int IW = 2;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    cim_psum_collector_if #(.NUM_COLS(NC), .ODATA_WIDTH(W), .IDX_W(IW)) bus ();

    cim_psum_collector #(.NUM_COLS(NC), .ODATA_WIDTH(W), .PSUM_DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "bench timed out");
    end

    // ---------------- reference model ----------------
    int       mq [NC][$];
    bit [3:0] m_ovf;
    int       m_rr;
    bit       m_lock;
    int       m_lock_idx;

    task automatic model_reset();
        for (int k = 0; k < NC; k++) mq[k].delete();
        m_ovf      = '0;
        m_rr       = 0;
        m_lock     = 1'b0;
        m_lock_idx = 0;
    endtask

    function automatic int m_grant();
        if (m_lock) return m_lock_idx;
        for (int i = 0; i < NC; i++) begin
            int j;
            j = (m_rr + i) % NC;
            if (bus.col_mask[j] && mq[j].size() > 0) return j;
        end
        return 0;
    endfunction

    function automatic bit m_valid();
        if (bus.mode) begin
            for (int k = 0; k < NC; k++) if (bus.col_mask[k] && mq[k].size() > 0) return 1'b1;
            return 1'b0;
        end
        if (bus.col_mask == '0) return 1'b0;
        for (int k = 0; k < NC; k++) if (bus.col_mask[k] && mq[k].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [NC*W-1:0] m_data();
        logic [NC*W-1:0] e;
        int              v;
        e = '0;
        if (bus.mode) begin
            v = mq[m_grant()][0];
            e[W-1:0] = v[W-1:0];
        end else begin
            for (int k = 0; k < NC; k++) begin
                if (bus.col_mask[k]) begin
                    v = mq[k][0];
                    e[k*W +: W] = v[W-1:0];
                end
            end
        end
        return e;
    endfunction

    function automatic logic [NC-1:0] m_empty();
        logic [NC-1:0] e;
        for (int k = 0; k < NC; k++) e[k] = (mq[k].size() == 0);
        return e;
    endfunction

    function automatic logic [NC-1:0] m_full();
        logic [NC-1:0] e;
        for (int k = 0; k < NC; k++) e[k] = (mq[k].size() == D);
        return e;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_update();
        bit v;
        int g;
        int val;
        if (bus.flush) begin
            model_reset();
            return;
        end
        v = m_valid();
        g = m_grant();
        if (v && bus.out_ready) begin
            if (bus.mode) begin
                void'(mq[g].pop_front());
                m_rr   = (g + 1) % NC;
                m_lock = 1'b0;
            end else begin
                for (int k = 0; k < NC; k++) if (bus.col_mask[k]) void'(mq[k].pop_front());
            end
        end else if (bus.mode && v && !m_lock) begin
            m_lock     = 1'b1;
            m_lock_idx = g;
        end
        for (int k = 0; k < NC; k++) begin
            if (bus.acc_ready[k] && bus.col_mask[k]) begin
                if (mq[k].size() < D) begin
                    val = int'(bus.mac_col_result[k*W +: W]);
                    mq[k].push_back(val);
                end else begin
                    m_ovf[k] = 1'b1;
                end
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        bus.acc_ready = '0;
        bus.flush     = 1'b0;
    endtask

    task automatic set_col(input int k, input int v);
        bus.acc_ready[k] = 1'b1;
        bus.mac_col_result[k*W +: W] = W'(v);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n              = 1'b0;
        bus.mode           = 1'b0;
        bus.col_mask       = '0;
        bus.acc_ready      = '0;
        bus.mac_col_result = '0;
        bus.flush          = 1'b0;
        bus.out_ready      = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_col_idx !== '0) begin
            n_fail++;
            $display("FAIL reset_out valid=%0b data=%0h idx=%0d required 0/0/0", bus.out_valid, bus.out_data, bus.out_col_idx);
        end
        n_tests++;
        if (bus.empty_vec !== 4'b1111 || bus.full_vec !== 4'b0000 || bus.overflow !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags empty=%b full=%b ovf=%b required 1111/0000/0000", bus.empty_vec, bus.full_vec, bus.overflow);
        end
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.empty_vec !== 4'b1111) begin
            n_fail++;
            $display("FAIL post_reset valid=%0b empty=%b required 0/1111", bus.out_valid, bus.empty_vec);
        end
    endtask

    task automatic test_aligned_basic();
        logic [NC*W-1:0] e;
        bus.mode = 1'b0; bus.col_mask = 4'b1111; bus.out_ready = 1'b1;
        set_col(0, 10); set_col(1, 20); set_col(2, 30); set_col(3, 40);
        tick();
        e = {21'd40, 21'd30, 21'd20, 21'd10};
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== e) begin
            n_fail++;
            $display("FAIL aligned_basic valid=%0b data=%0h required 1/%0h", bus.out_valid, bus.out_data, e);
        end
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.empty_vec !== 4'b1111) begin
            n_fail++;
            $display("FAIL aligned_drain valid=%0b empty=%b required 0/1111", bus.out_valid, bus.empty_vec);
        end
    endtask

    task automatic test_aligned_masked();
        logic [NC*W-1:0] e;
        bus.mode = 1'b0; bus.col_mask = 4'b0101; bus.out_ready = 1'b1;
        set_col(0, 5); set_col(1, 9);
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.empty_vec !== 4'b1110) begin
            n_fail++;
            $display("FAIL masked_wait valid=%0b empty=%b required 0/1110", bus.out_valid, bus.empty_vec);
        end
        tick();
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL masked_wait2 valid=%0b required 0", bus.out_valid);
        end
        set_col(2, 7);
        tick();
        e = {21'd0, 21'd7, 21'd0, 21'd5};
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== e) begin
            n_fail++;
            $display("FAIL masked_beat valid=%0b data=%0h required 1/%0h", bus.out_valid, bus.out_data, e);
        end
        tick();
        n_tests++;
        if (bus.empty_vec !== 4'b1111 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL masked_drain empty=%b valid=%0b required 1111/0", bus.empty_vec, bus.out_valid);
        end
    endtask

    task automatic test_serial_rr();
        int exp_idx [4] = '{0, 1, 3, 0};
        int exp_dat [4] = '{11, 12, 14, 21};
        bus.mode = 1'b1; bus.col_mask = 4'b1111; bus.out_ready = 1'b0;
        set_col(0, 11); set_col(1, 12); set_col(3, 14);
        tick();
        bus.out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_col_idx !== IW'(exp_idx[b]) ||
                bus.out_data !== (NC*W)'(exp_dat[b])) begin
                n_fail++;
                $display("FAIL serial_rr beat%0d valid=%0b idx=%0d data=%0h required 1/%0d/%0h",
                         b, bus.out_valid, bus.out_col_idx, bus.out_data, exp_idx[b], exp_dat[b]);
            end
            if (b == 1) set_col(0, 21);
            tick();
        end
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.empty_vec !== 4'b1111) begin
            n_fail++;
            $display("FAIL serial_rr_end valid=%0b empty=%b required 0/1111", bus.out_valid, bus.empty_vec);
        end
    endtask

    task automatic test_backpressure();
        bus.mode = 1'b1; bus.col_mask = 4'b1111; bus.out_ready = 1'b0;
        bus.flush = 1'b1;
        tick();
        set_col(2, 33);
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_col_idx !== 2'd2 || bus.out_data !== (NC*W)'(33)) begin
            n_fail++;
            $display("FAIL bp_first valid=%0b idx=%0d data=%0h required 1/2/21", bus.out_valid, bus.out_col_idx, bus.out_data);
        end
        set_col(0, 44);
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_col_idx !== 2'd2 || bus.out_data !== (NC*W)'(33)) begin
                n_fail++;
                $display("FAIL bp_hold cyc%0d valid=%0b idx=%0d data=%0h required 1/2/21", c, bus.out_valid, bus.out_col_idx, bus.out_data);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_col_idx !== 2'd0 || bus.out_data !== (NC*W)'(44)) begin
            n_fail++;
            $display("FAIL bp_next valid=%0b idx=%0d data=%0h required 1/0/2c", bus.out_valid, bus.out_col_idx, bus.out_data);
        end
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_end valid=%0b required 0", bus.out_valid);
        end
    endtask

    task automatic test_overflow();
        int exp_head [4] = '{2, 3, 5, 0};
        bus.mode = 1'b0; bus.col_mask = 4'b0010; bus.out_ready = 1'b0;
        for (int v = 1; v <= 3; v++) begin
            set_col(1, v);
            tick();
        end
        n_tests++;
        if (bus.full_vec !== 4'b0010 || bus.overflow !== 4'b0000) begin
            n_fail++;
            $display("FAIL ovf_full full=%b ovf=%b required 0010/0000", bus.full_vec, bus.overflow);
        end
        set_col(1, 4);
        tick();
        n_tests++;
        if (bus.overflow !== 4'b0010 || bus.full_vec !== 4'b0010 || bus.out_data[W +: W] !== 21'd1) begin
            n_fail++;
            $display("FAIL ovf_drop ovf=%b full=%b head=%0d required 0010/0010/1", bus.overflow, bus.full_vec, bus.out_data[W +: W]);
        end
        bus.out_ready = 1'b1;
        set_col(1, 5);
        tick();
        n_tests++;
        if (bus.full_vec !== 4'b0010 || bus.overflow !== 4'b0010) begin
            n_fail++;
            $display("FAIL ovf_pushpop full=%b ovf=%b required 0010/0010", bus.full_vec, bus.overflow);
        end
        for (int b = 0; b < 4; b++) begin
            n_tests++;
            if (b < 3 && (bus.out_valid !== 1'b1 || bus.out_data[W +: W] !== W'(exp_head[b]))) begin
                n_fail++;
                $display("FAIL ovf_drain beat%0d valid=%0b head=%0d required 1/%0d", b, bus.out_valid, bus.out_data[W +: W], exp_head[b]);
            end else if (b == 3 && (bus.out_valid !== 1'b0 || bus.empty_vec !== 4'b1111 || bus.overflow !== 4'b0010)) begin
                n_fail++;
                $display("FAIL ovf_drained valid=%0b empty=%b ovf=%b required 0/1111/0010", bus.out_valid, bus.empty_vec, bus.overflow);
            end
            if (b < 3) tick();
        end
        bus.out_ready = 1'b0;
        set_col(1, 6);
        tick();
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        set_col(1, 7);
        tick();
        n_tests++;
        if (bus.empty_vec !== 4'b1111 || bus.overflow !== 4'b0000 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush empty=%b ovf=%b valid=%0b required 1111/0000/0", bus.empty_vec, bus.overflow, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        bus.mode = 1'b1; bus.col_mask = 4'b1111; bus.out_ready = 1'b0;
        set_col(0, 100); set_col(1, 200);
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre valid=%0b required 1", bus.out_valid);
        end
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_col_idx !== '0 ||
            bus.empty_vec !== 4'b1111 || bus.full_vec !== 4'b0000 || bus.overflow !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstmid_now valid=%0b data=%0h idx=%0d empty=%b full=%b ovf=%b required reset values",
                     bus.out_valid, bus.out_data, bus.out_col_idx, bus.empty_vec, bus.full_vec, bus.overflow);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_idle valid=%0b required 0", bus.out_valid);
        end
        set_col(3, 300);
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_col_idx !== 2'd3 || bus.out_data !== (NC*W)'(300)) begin
            n_fail++;
            $display("FAIL rstmid_new valid=%0b idx=%0d data=%0h required 1/3/12c", bus.out_valid, bus.out_col_idx, bus.out_data);
        end
        tick();
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 6; seg++) begin
            bus.mode     = seg[0];
            bus.col_mask = 4'($urandom_range(0, 15));
            bus.flush    = 1'b1;
            tick();
            for (int c = 0; c < 150; c++) begin
                for (int k = 0; k < NC; k++) begin
                    if ($urandom_range(0, 1) == 1) set_col(k, int'($urandom_range(0, (1 << W) - 1)));
                end
                bus.out_ready = ($urandom_range(0, 3) != 0);
                bus.flush     = ($urandom_range(0, 63) == 0);
                tick();
                n_tests++;
                if (bus.out_valid !== m_valid() || bus.empty_vec !== m_empty() ||
                    bus.full_vec !== m_full() || bus.overflow !== m_ovf) begin
                    n_fail++;
                    $display("FAIL rand_flags seg%0d cyc%0d valid=%0b empty=%b full=%b ovf=%b required %0b/%b/%b/%b",
                             seg, c, bus.out_valid, bus.empty_vec, bus.full_vec, bus.overflow,
                             m_valid(), m_empty(), m_full(), m_ovf);
                end
                if (m_valid()) begin
                    n_tests++;
                    if (bus.out_data !== m_data() || bus.out_col_idx !== IW'(bus.mode ? m_grant() : 0)) begin
                        n_fail++;
                        $display("FAIL rand_beat seg%0d cyc%0d data=%0h idx=%0d required %0h/%0d",
                                 seg, c, bus.out_data, bus.out_col_idx, m_data(), bus.mode ? m_grant() : 0);
                    end
                end
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_aligned_basic();
        test_aligned_masked();
        test_serial_rr();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cim_psum_collector.md
Name: cim_psum_collector

Overview:
- Per-column partial-sum collection stage for a CIM macro; sits between the column MAC/accumulator outputs and the downstream psum consumer.
- Each column gets a parametrised-depth FIFO, an overflow flag and a column-enable mask.
- Output is a valid/ready stream with two modes: ALIGNED (all enabled columns pop together as one wide beat) and SERIAL (one column per beat, round-robin, with column index).

Parameters:
NUM_COLS, 32, number of columns.
ODATA_WIDTH, 21, psum width per column.
PSUM_DEPTH, 4, FIFO entries per column, >=2, any integer (not just power of two).
CNT_W, $clog2(PSUM_DEPTH+1), occupancy counter width (derived).
IDX_W, $clog2(NUM_COLS), column index width (derived, min 1).

Ports:
clk  in  1  clock
rst_n  in  1  reset
mode  in  1  0=ALIGNED, 1=SERIAL
col_mask  in  NUM_COLS  column enable; unmasked columns never push or pop
acc_ready  in  NUM_COLS  per-column result strobe
mac_col_result  in  NUM_COLS*ODATA_WIDTH  per-column results, column k at [k*ODATA_WIDTH +: ODATA_WIDTH]
flush  in  1  synchronous clear of FIFOs, flags and arbiter
out_valid  out  1  output beat available
out_ready  in  1  consumer accepts beat
out_data  out  NUM_COLS*ODATA_WIDTH  ALIGNED: column k head in slot k; SERIAL: selected head in slot 0, rest zero
out_col_idx  out  IDX_W  SERIAL: selected column; ALIGNED: 0
empty_vec  out  NUM_COLS  per-column FIFO empty
full_vec  out  NUM_COLS  per-column FIFO full
overflow  out  NUM_COLS  sticky per-column drop flag

Behaviour:
- Single clock clk; reset is asynchronous, active-low (rst_n).
- Reset values: out_valid=0, out_data=0, out_col_idx=0, empty_vec all 1, full_vec=0, overflow=0. Read/write pointers, counts and RR pointer are 0; storage is zeroed.
- Push: column k writes when acc_ready[k] & col_mask[k].
  - Full with no same-cycle pop: data dropped, overflow[k] set.
  - Full with same-cycle pop: write accepted, count unchanged.
- Pointers wrap at PSUM_DEPTH-1 -> 0 (explicit compare, not modulo power-of-two).
- Latency: push in cycle N -> visible at head, empty_vec[k]=0 and eligible for out_valid in cycle N+1. No empty-FIFO bypass.
- ALIGNED mode:
  - out_valid = (col_mask != 0) & all masked columns non-empty.
  - out_data slot k = head[k] if masked, else 0.
  - On out_valid & out_ready, every masked column pops once.
- SERIAL mode:
  - Candidates are masked, non-empty columns.
  - Grant = first candidate at or after rr_ptr, wrapping modulo NUM_COLS.
  - out_valid = any candidate. out_col_idx = grant.
  - On handshake, pop grant and set rr_ptr = grant+1 (wrap to 0).
- Stability: while out_valid & !out_ready, out_data/out_col_idx/out_valid hold.
  - SERIAL: grant is latched on the first cycle valid is raised and held until the handshake, even if a higher-priority column fills meanwhile.
- flush, one cycle: next cycle all FIFOs empty, overflow=0, rr_ptr=0, grant lock released, out_valid=0. Overrides push and pop in the same cycle; an out_ready handshake in the flush cycle is discarded.
- mode and col_mask must be changed only while all FIFOs are empty or in the flush cycle; otherwise output is unspecified (no X on outputs required).
- rst_n assertion mid-stream: immediate clear to reset values, regardless of in-flight handshake.
- Counts are exact 0..PSUM_DEPTH. full_vec[k] = count==PSUM_DEPTH; empty_vec[k] = count==0.

Decomposition:
- Package cim_psum_pkg holds:
  - mode enum PSUM_MODE_ALIGNED=0, PSUM_MODE_SERIAL=1;
  - width helper function for derived widths (CNT_W, IDX_W).
- Sub-module cim_psum_fifo: one column FIFO with push, pop, flush, head, empty, full, overflow. Generated NUM_COLS times.
- Aligned/serial output mux and round-robin arbiter stay in the top level.

Test Plan (NUM_COLS=4, ODATA_WIDTH=21, PSUM_DEPTH=3):
- ALIGNED basic: mask=4'b1111; strobe all columns at cycle 0 with 10,20,30,40; ready=1 -> out_valid at cycle 1, out_data slots {10,20,30,40}, then empty_vec=4'b1111.
- ALIGNED masked/skewed: mask=4'b0101; col0=5 at cycle 0, col2=7 at cycle 3 -> out_valid low until cycle 4, then slots {5,0,7,0}; col1 strobe ignored.
- SERIAL round-robin: mask=4'b1111; cols 0,1,3 each hold one entry (11,12,14); ready=1 -> beats idx 0,1,3 with data 11,12,14, then valid=0. A later col0 push is served only after rr_ptr wraps.
- Backpressure: SERIAL, ready=0, only col2 filled (valid, idx=2); then push col0 -> idx stays 2 and data is stable until ready=1.
- Overflow/full: 4 pushes of 1,2,3,4 to col1 with no pops -> full_vec[1]=1, overflow[1]=1, drains 1,2,3. Push+pop while full -> accepted, overflow unchanged. flush -> overflow=0, empty.
- Reset mid-stream: assert rst_n low with 2 entries pending and valid high -> outputs at reset values immediately; after release valid stays 0 until a new push.
